// File: rtl/viterbi_pkg.sv
// Shared decoder definitions: FIFO width helpers and error-flag bit positions
// used by the status register map.
package viterbi_pkg;

  localparam int FIFO_ERR_OVF_BIT = 0;
  localparam int FIFO_ERR_UDF_BIT = 1;
  localparam int FIFO_ERR_W       = 2;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo_flex: one synchronous write port, one
// asynchronous read port. Contents are never reset.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_W      = 4
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [PTR_W-1:0]      wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [PTR_W-1:0]      rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      r_mem[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = r_mem[rd_addr_i];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, level, thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_flex
  import viterbi_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en_i,
  input  logic [DATA_WIDTH-1:0]          wr_data_i,
  output logic                           full_o,
  output logic                           almost_full_o,
  input  logic                           rd_en_i,
  output logic [DATA_WIDTH-1:0]          rd_data_o,
  output logic                           rd_valid_o,
  output logic                           empty_o,
  output logic                           almost_empty_o,
  output logic [lvl_w(FIFO_DEPTH)-1:0]   level_o,
  output logic                           overflow_o,
  output logic                           underflow_o,
  input  logic                           err_clr_i
);

  localparam int                PTR_W     = ptr_w(FIFO_DEPTH);
  localparam int                LVL_W     = lvl_w(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [LVL_W-1:0]  DEPTH_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]  AF_LVL    = LVL_W'(AF_THRESH);
  localparam logic [LVL_W-1:0]  AE_LVL    = LVL_W'(AE_THRESH);

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  assign full_o         = (r_level == DEPTH_LVL);
  assign empty_o        = (r_level == '0);
  assign almost_full_o  = (r_level >= AF_LVL);
  assign almost_empty_o = (r_level <= AE_LVL);
  assign level_o        = r_level;
  assign overflow_o     = r_overflow;
  assign underflow_o    = r_underflow;

  // A full FIFO still takes a write when the same cycle pops a word.
  assign w_rd_acc = rd_en_i & ~empty_o;
  assign w_wr_acc = wr_en_i & (~full_o | w_rd_acc);

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .PTR_W      (PTR_W)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (w_wr_acc),
    .wr_addr_i (r_wr_ptr),
    .wr_data_i (wr_data_i),
    .rd_addr_i (r_rd_ptr),
    .rd_data_o (w_ram_rdata)
  );

  // pointers wrap explicitly so any depth works
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
    end
  end

  // occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // sticky errors; a new error beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en_i & ~w_wr_acc) begin
        r_overflow <= 1'b1;
      end else if (err_clr_i) begin
        r_overflow <= 1'b0;
      end
      if (rd_en_i & empty_o) begin
        r_underflow <= 1'b1;
      end else if (err_clr_i) begin
        r_underflow <= 1'b0;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data_o  = w_ram_rdata;
  assign rd_valid_o = ~empty_o;
`else
  // registered pop: data one cycle after the accepted read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= w_rd_acc;
      if (w_rd_acc) begin
        rd_data_o <= w_ram_rdata;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench for sync_fifo_flex: a depth-16 and a depth-5 instance
// checked every cycle against a queue-based reference model.
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        wr  [2];
  logic        rd  [2];
  logic        clr [2];
  logic [15:0] wd  [2];

  logic [1:0]  full_w, af_w, empty_w, ae_w, ovf_w, udf_w, rdv_w;
  logic [15:0] rdd0, rdd1;
  logic [4:0]  lvl0;
  logic [2:0]  lvl1;

  sync_fifo_flex #(.DATA_WIDTH(16), .FIFO_DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) u_dut16 (
    .clk(clk), .rst(rst),
    .wr_en_i(wr[0]), .wr_data_i(wd[0]), .full_o(full_w[0]), .almost_full_o(af_w[0]),
    .rd_en_i(rd[0]), .rd_data_o(rdd0), .rd_valid_o(rdv_w[0]), .empty_o(empty_w[0]),
    .almost_empty_o(ae_w[0]), .level_o(lvl0), .overflow_o(ovf_w[0]), .underflow_o(udf_w[0]),
    .err_clr_i(clr[0])
  );

  sync_fifo_flex #(.DATA_WIDTH(16), .FIFO_DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) u_dut5 (
    .clk(clk), .rst(rst),
    .wr_en_i(wr[1]), .wr_data_i(wd[1]), .full_o(full_w[1]), .almost_full_o(af_w[1]),
    .rd_en_i(rd[1]), .rd_data_o(rdd1), .rd_valid_o(rdv_w[1]), .empty_o(empty_w[1]),
    .almost_empty_o(ae_w[1]), .level_o(lvl1), .overflow_o(ovf_w[1]), .underflow_o(udf_w[1]),
    .err_clr_i(clr[1])
  );

  // reference model
  int          depth [2] = '{16, 5};
  int          af_th [2] = '{14, 4};
  int          ae_th [2] = '{2, 1};
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  bit          m_ovf [2];
  bit          m_udf [2];
  bit          m_rdv [2];
  logic [15:0] m_rdd [2];

  int    checks   = 0;
  int    failures = 0;
  string cur_ph   = "init";

  function automatic int msize(input int w);
    return (w == 0) ? q0.size() : q1.size();
  endfunction

  task automatic mpush(input int w, input logic [15:0] d);
    if (w == 0) q0.push_back(d); else q1.push_back(d);
  endtask

  task automatic mpop(input int w, output logic [15:0] d);
    if (w == 0) d = q0.pop_front(); else d = q1.pop_front();
  endtask

  task automatic mreset();
    q0.delete();
    q1.delete();
    for (int w = 0; w < 2; w++) begin
      m_ovf[w] = 1'b0; m_udf[w] = 1'b0; m_rdv[w] = 1'b0; m_rdd[w] = 16'h0000;
    end
  endtask

  function automatic string tg(input int w, input string s);
    return $sformatf("%s/i%0d/%s", cur_ph, w, s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    logic [15:0] h;
    for (int w = 0; w < 2; w++) begin
      n = msize(w);
      chk(tg(w, "level"), (w == 0) ? 32'(lvl0) : 32'(lvl1), 32'(n));
      chk(tg(w, "full"),  32'(full_w[w]),  32'(n == depth[w]));
      chk(tg(w, "empty"), 32'(empty_w[w]), 32'(n == 0));
      chk(tg(w, "afull"), 32'(af_w[w]),    32'(n >= af_th[w]));
      chk(tg(w, "aempty"),32'(ae_w[w]),    32'(n <= ae_th[w]));
      chk(tg(w, "ovf"),   32'(ovf_w[w]),   32'(m_ovf[w]));
      chk(tg(w, "udf"),   32'(udf_w[w]),   32'(m_udf[w]));
`ifdef SYNC_FIFO_FWFT_EN
      chk(tg(w, "rd_valid"), 32'(rdv_w[w]), 32'(n > 0));
      if (n > 0) begin
        h = (w == 0) ? q0[0] : q1[0];
        chk(tg(w, "rd_data"), (w == 0) ? 32'(rdd0) : 32'(rdd1), 32'(h));
      end
`else
      chk(tg(w, "rd_valid"), 32'(rdv_w[w]), 32'(m_rdv[w]));
      chk(tg(w, "rd_data"), (w == 0) ? 32'(rdd0) : 32'(rdd1), 32'(m_rdd[w]));
`endif
    end
  endtask

  // one clock: model follows the FIFO rules, then outputs are compared
  task automatic step();
    bit f, e, ra, wa;
    logic [15:0] v;
    @(posedge clk);
    for (int w = 0; w < 2; w++) begin
      f  = (msize(w) == depth[w]);
      e  = (msize(w) == 0);
      ra = rd[w] && !e;
      wa = wr[w] && (!f || ra);
      m_rdv[w] = 1'b0;
      if (ra) begin
        mpop(w, v);
        m_rdd[w] = v;
        m_rdv[w] = 1'b1;
      end
      if (wa) mpush(w, wd[w]);
      if (wr[w] && !wa) m_ovf[w] = 1'b1; else if (clr[w]) m_ovf[w] = 1'b0;
      if (rd[w] && e)   m_udf[w] = 1'b1; else if (clr[w]) m_udf[w] = 1'b0;
    end
    #1;
    check_all();
  endtask

  task automatic idle_in();
    for (int w = 0; w < 2; w++) begin
      wr[w] = 1'b0; rd[w] = 1'b0; clr[w] = 1'b0; wd[w] = 16'h0000;
    end
  endtask

  task automatic op(input int w, input bit wr_, input logic [15:0] d, input bit rd_, input bit clr_);
    idle_in();
    wr[w] = wr_; wd[w] = d; rd[w] = rd_; clr[w] = clr_;
    step();
  endtask

  task automatic do_reset(input bit wait_edge);
    idle_in();
    rst = 1'b1;
    if (wait_edge) @(posedge clk);
    #1;
    mreset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    idle_in();
    cur_ph = "reset";
    do_reset(1'b1);

    cur_ph = "fill16";
    for (int i = 1; i <= 16; i++) op(0, 1'b1, 16'(i), 1'b0, 1'b0);
    chk("fill16/full_at_16", 32'(full_w[0]), 32'd1);
    cur_ph = "drain16";
    for (int i = 0; i < 16; i++) op(0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(0, 1'b0, 16'h0000, 1'b0, 1'b0);

    cur_ph = "wrap5";
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 5; i++) op(1, 1'b1, 16'(16'h00A0 + i), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) op(1, 1'b0, 16'h0000, 1'b1, 1'b0);
    end

    cur_ph = "fullwr";
    for (int i = 0; i < 16; i++) op(0, 1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
    op(0, 1'b1, 16'hBEEF, 1'b1, 1'b0);
    op(0, 1'b1, 16'hDEAD, 1'b0, 1'b0);
    op(0, 1'b0, 16'h0000, 1'b0, 1'b0);
    op(0, 1'b1, 16'hDEAD, 1'b0, 1'b1);
    op(0, 1'b0, 16'h0000, 1'b0, 1'b1);

    cur_ph = "emptywr";
    for (int i = 0; i < 16; i++) op(0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(0, 1'b1, 16'h5A5A, 1'b1, 1'b0);
    op(0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(0, 1'b0, 16'h0000, 1'b1, 1'b1);
    op(0, 1'b0, 16'h0000, 1'b0, 1'b1);

    cur_ph = "latency";
    op(0, 1'b1, 16'h1234, 1'b0, 1'b0);
    op(0, 1'b0, 16'h0000, 1'b0, 1'b0);
    op(0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(0, 1'b0, 16'h0000, 1'b0, 1'b0);

    cur_ph = "midrst";
    for (int i = 0; i < 7; i++) op(0, 1'b1, 16'(16'h0700 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) op(1, 1'b1, 16'(16'h0050 + i), 1'b0, 1'b0);
    op(0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(1, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("midrst/level_before", 32'(lvl0), 32'd6);
    do_reset(1'b0);
    cur_ph = "refill";
    for (int i = 0; i < 3; i++) op(0, 1'b1, 16'(16'h0C00 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) op(0, 1'b0, 16'h0000, 1'b1, 1'b0);

    cur_ph = "random";
    for (int c = 0; c < 600; c++) begin
      for (int w = 0; w < 2; w++) begin
        wr[w]  = (c < 300) ? ($urandom_range(3, 0) != 0) : ($urandom_range(3, 0) == 0);
        rd[w]  = (c < 300) ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0);
        clr[w] = ($urandom_range(15, 0) == 0);
        wd[w]  = 16'($urandom);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
